// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable frame format.
//
// Words written on the stream port (tvalid/tready/tdata) are queued in a small FIFO and
// serialised LSB-first on tx as: start, DATA_WIDTH data bits, optional parity, stop bit(s).
// Queued words are sent back to back with no idle gap between frames.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   tvalid     in   input word valid
//   tready     out  FIFO can accept a word (registered)
//   tdata      in   word to send, DATA_WIDTH bits
//   send_break in   request a line break (only with UART_TX_FIFO_BREAK_EN)
//   tx         out  serial line, idle high, driven from a flop
//   busy       out  frame in progress or FIFO non-empty (registered)
//   fifo_level out  current FIFO occupancy
//
// Optional feature macro: UART_TX_FIFO_BREAK_EN adds send_break and BREAK_BITS. A break holds
// tx low for BREAK_BITS bit periods followed by one high stop period. A request arriving
// mid-frame is latched and served after that frame, ahead of any queued words.

module uart_tx_fifo #(
  parameter int unsigned CYCLES_PER_BIT = 434,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned FIFO_DEPTH     = 4
`ifdef UART_TX_FIFO_BREAK_EN
  ,
  parameter int unsigned BREAK_BITS     = 13
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tvalid,
  output logic                          tready,
  input  logic [DATA_WIDTH-1:0]         tdata,
`ifdef UART_TX_FIFO_BREAK_EN
  input  logic                          send_break,
`endif
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;
  localparam int unsigned BaudW = $clog2(CYCLES_PER_BIT);
`ifdef UART_TX_FIFO_BREAK_EN
  localparam int unsigned MaxBits = (BREAK_BITS > DATA_WIDTH) ? BREAK_BITS : DATA_WIDTH;
`else
  localparam int unsigned MaxBits = DATA_WIDTH;
`endif
  localparam int unsigned BitW  = $clog2(MaxBits);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4
`ifdef UART_TX_FIFO_BREAK_EN
    ,
    StBreak    = 3'd5,
    StBrkStop  = 3'd6
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [BaudW-1:0]        baud_q, baud_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    tready_q, tready_d;

  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]         level_q, level_d;
  logic                    push, pop;
  logic [DATA_WIDTH-1:0]   head;
  logic                    baud_wrap;

`ifdef UART_TX_FIFO_BREAK_EN
  logic                    brk_pend_q, brk_pend_d;
  logic                    brk_req;
  assign brk_req = brk_pend_q | send_break;
`endif

  assign push      = tvalid & tready_q;
  assign head      = mem_q[rd_ptr_q];
  assign baud_wrap = (baud_q == BaudW'(CYCLES_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_wrap ? '0 : baud_q + BaudW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pop     = 1'b0;
`ifdef UART_TX_FIFO_BREAK_EN
    brk_pend_d = brk_pend_q | send_break;
`endif

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        bit_d  = '0;
`ifdef UART_TX_FIFO_BREAK_EN
        if (brk_req) begin
          state_d    = StBreak;
          brk_pend_d = 1'b0;
        end else
`endif
        if (level_q != '0) begin
          pop     = 1'b1;
          shreg_d = head;
          par_d   = (PARITY == 1) ? ~^head : ^head;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_wrap) state_d = StData;
      end
      StData: begin
        if (baud_wrap) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BitW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (baud_wrap) state_d = StStop;
      end
      StStop: begin
        if (baud_wrap) begin
          if (bit_q == BitW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = StIdle;
`ifdef UART_TX_FIFO_BREAK_EN
            if (brk_req) begin
              state_d    = StBreak;
              brk_pend_d = 1'b0;
            end else
`endif
            // Zero-gap chaining: pop the next word straight into a new start bit.
            if (level_q != '0) begin
              pop     = 1'b1;
              shreg_d = head;
              par_d   = (PARITY == 1) ? ~^head : ^head;
              state_d = StStart;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
`ifdef UART_TX_FIFO_BREAK_EN
      StBreak: begin
        if (baud_wrap) begin
          if (bit_q == BitW'(BREAK_BITS - 1)) begin
            bit_d   = '0;
            state_d = StBrkStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StBrkStop: begin
        if (baud_wrap) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase

    // tx follows the current state one cycle late, so every bit period keeps its length.
    case (state_q)
      StStart:   tx_d = 1'b0;
      StData:    tx_d = shreg_q[0];
      StParity:  tx_d = par_q;
`ifdef UART_TX_FIFO_BREAK_EN
      StBreak:   tx_d = 1'b0;
`endif
      default:   tx_d = 1'b1;
    endcase

    busy_d   = (state_d != StIdle) || (level_d != '0);
    tready_d = (level_d != LvlW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      tready_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
`ifdef UART_TX_FIFO_BREAK_EN
      brk_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      tready_q   <= tready_d;
      wr_ptr_q   <= wr_ptr_q + AddrW'(push);
      rd_ptr_q   <= rd_ptr_q + AddrW'(pop);
      level_q    <= level_d;
`ifdef UART_TX_FIFO_BREAK_EN
      brk_pend_q <= brk_pend_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tready     = tready_q;
  assign fifo_level = level_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised next-generation UART transmitter.
- Accepts words on an AXI-stream-style slave port into an internal FIFO and serialises them LSB-first onto `tx`.
- Frame format is configurable: data width, parity mode and stop-bit count.
- Drop-in successor to the single-word UART TX; the `clk`, `tx`, `tvalid`, `tready` and `tdata` ports keep their names and meaning.

Parameters:
- `CYCLES_PER_BIT`, default 434: clocks per bit period (50 MHz / 115200); legal range >= 2.
- `DATA_WIDTH`, default 8: data bits per frame; legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `FIFO_DEPTH`, default 4: input FIFO entries; power of two, 2..64.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `tvalid`  in  1  input word valid.
- `tready`  out  1  FIFO can accept a word.
- `tdata`  in  `DATA_WIDTH`  word to send.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress or FIFO non-empty.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  current FIFO occupancy.

Behaviour:
- Reset (`rst_n` low at a rising edge):
  - `tx` = 1, `tready` = 0, `busy` = 0, `fifo_level` = 0.
  - FIFO is emptied, FSM returns to IDLE, baud and bit counters are cleared.
- Reset mid-frame aborts the frame immediately: `tx` is high on the next cycle and no partial bits follow.
- `tready` = 1 out of reset whenever `fifo_level` < `FIFO_DEPTH`. It is registered and goes low in the cycle the FIFO becomes full.
- Transfer: a word is written to the FIFO on a rising edge with `tvalid` && `tready`. `tdata` is captured at that edge.
- Simultaneous write and FIFO pop in one cycle: level is unchanged. A write while full cannot occur, because `tready` = 0.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop the head into the shift register and enter START.
  - START: `tx` = 0 for `CYCLES_PER_BIT` clocks.
  - DATA: `DATA_WIDTH` bits, LSB first, each held `CYCLES_PER_BIT` clocks. The bit index counts 0..`DATA_WIDTH`-1.
  - PARITY: present only if `PARITY` != 0. Odd parity gives ~^data; even parity gives ^data. Held one bit period.
  - STOP: `tx` = 1 for `STOP_BITS` x `CYCLES_PER_BIT` clocks. At the end, if the FIFO is non-empty, pop and go directly to START with zero idle gap; otherwise go to IDLE.
- Baud counter counts 0..`CYCLES_PER_BIT`-1 and wraps; the bit advances on wrap. All bit periods are exact, with no cumulative drift.
- Frame length = (1 + `DATA_WIDTH` + (`PARITY` != 0) + `STOP_BITS`) x `CYCLES_PER_BIT` clocks.
- Latency: with the FSM idle and the FIFO empty, a word accepted at edge N drives `tx` low from edge N+2. This is 1 cycle of FIFO write plus 1 cycle of pop into the registered `tx`.
- `tx` is driven from a flop; it is glitch-free.
- `busy` = (state != IDLE) || (`fifo_level` != 0), registered.

Optional Feature:
- Macro: `UART_TX_FIFO_BREAK_EN`.
- When defined:
  - Adds input `send_break` (1 bit) and parameter `BREAK_BITS` (default 13).
  - A `send_break` pulse seen in IDLE with the FIFO empty drives `tx` = 0 for `BREAK_BITS` x `CYCLES_PER_BIT` clocks.
  - This is followed by one stop period of `tx` = 1, then a return to IDLE.
  - `send_break` outside IDLE is latched and served after the current frame, taking priority over the FIFO.
  - `busy` = 1 during a break.
- When undefined: no port, no parameter, no break logic; `tx` never stays low longer than one frame.

Test Plan:
- Defaults with `CYCLES_PER_BIT`=4: send 0xA5 -> `tx` low at edge N+2; bits 1,0,1,0,0,1,0,1 with 4 clocks each; stop high; frame = 40 clocks; `busy` falls afterward.
- `PARITY`=2, `STOP_BITS`=2, `DATA_WIDTH`=7: send 0x35 -> parity bit = 0, two stop periods, frame = 44 clocks at `CYCLES_PER_BIT`=4. Repeat with `PARITY`=1 -> parity bit = 1.
- `FIFO_DEPTH`=4, `tvalid` held high with 6 random words -> `tready` drops after the 5th accept (4 queued plus 1 popped). All 6 words are received in order, with no idle gap between frames.
- Reset pulse mid-DATA of the 2nd of 3 queued words -> `tx`=1 next cycle, `fifo_level`=0, `tready`=0 during reset; no further frames; a clean frame after re-send.
- Stress with randomised `tvalid` and the bench UART receiver checking every bit centre over 200 words -> zero mismatches, `CHECK_EQUAL` passes, within `WATCHDOG`.
- With `UART_TX_FIFO_BREAK_EN` defined: `send_break` during a frame -> the frame completes, then `tx` low for exactly 52 clocks (13 x 4), then a high stop period before the next queued word.
